// File: rtl/panda_mem_loader.sv
// panda_mem_loader
//   Write-back stage feeding the PANDA accelerator memories. An address token
//   and a data token are taken together while the load controller enables
//   streaming. The pair is tagged with the memory select and buffered. One
//   registered write is then issued to the selected memory.
//
// Ports
//   clk_i, rst_i   clock, asynchronous active-high reset
//   clear_i        synchronous soft clear (same effect as reset)
//   en_i, sel_i    stream enable and memory select from the load controller
//   addr_*         byte-address token stream (valid in, ready out)
//   data_*         data token stream (valid in, ready out)
//   mem_we_o       one-hot write enable {wfc, wconv, act, instr, cfg}
//   mem_addr_o     word address, mem_wdata_o write data (held between writes)
//   mem_stall_i    target memory busy; the registered write is held
//   words_o        completed writes since the last clear or select change
//   busy_o         FSM active or pair buffer non-empty
//   err_o          sticky {illegal/null select, misaligned address}
module panda_mem_loader #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned ADDR_W    = 12,
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clear_i,
  input  logic              en_i,
  input  logic [2:0]        sel_i,
  input  logic              addr_valid_i,
  input  logic [31:0]       addr_i,
  output logic              addr_ready_o,
  input  logic              data_valid_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              data_ready_o,
  output logic [4:0]        mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_stall_i,
  output logic [15:0]       words_o,
  output logic              busy_o,
  output logic [1:0]        err_o
);

  localparam int unsigned PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int unsigned AW    = ADDR_W + 2;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t      state, state_nxt;
  logic [2:0]  cur_sel;
  logic        latch_sel;
  logic        clr_words;

  logic [2:0]        buf_sel  [BUF_DEPTH];
  logic [AW-1:0]     buf_addr [BUF_DEPTH];
  logic [DATA_W-1:0] buf_data [BUF_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [PTR_W:0]    count;
  logic              full, empty;

  logic              sel_change, accept, head_avail, pop;
  logic [2:0]        head_sel;
  logic [AW-1:0]     head_addr;
  logic [DATA_W-1:0] head_data;
  logic [4:0]        head_we;
  logic              head_misalign, head_bad_sel, head_ok;

  // Byte-address bits above the word address select nothing in these memories.
  logic unused_addr_bits;
  assign unused_addr_bits = ^addr_i[31:AW];

  assign full  = (count == (PTR_W+1)'(BUF_DEPTH));
  assign empty = (count == '0);

  // A select change seen in RUN blocks accepts in the same cycle, so a pair
  // carrying the new select can never overtake buffered pairs of the old one.
  assign sel_change = (state == RUN) && en_i && (sel_i != cur_sel);
  assign accept     = en_i && addr_valid_i && data_valid_i && !full &&
                      (state != DRAIN) && !sel_change && !clear_i && !rst_i;

  assign addr_ready_o = accept;
  assign data_ready_o = accept;

  // With an empty buffer the incoming pair is the head: it is pushed and popped
  // in the same cycle. This gives a one-cycle accept-to-write latency while the
  // occupancy stays at zero.
  assign head_sel   = empty ? sel_i             : buf_sel[rd_ptr];
  assign head_addr  = empty ? addr_i[AW-1:0]    : buf_addr[rd_ptr];
  assign head_data  = empty ? data_i            : buf_data[rd_ptr];
  assign head_avail = !empty || accept;
  assign pop        = head_avail && !mem_stall_i;

  always_comb begin
    head_we = '0;
    case (head_sel)
      3'd0:    head_we = 5'b00001;
      3'd1:    head_we = 5'b00010;
      3'd4:    head_we = 5'b00100;
      3'd5:    head_we = 5'b01000;
      3'd6:    head_we = 5'b10000;
      default: head_we = '0;
    endcase
  end

  assign head_bad_sel  = (head_we == '0);
  assign head_misalign = |head_addr[1:0];
  assign head_ok       = !head_bad_sel && !head_misalign;

  assign busy_o = (state != IDLE) || !empty;

  always_comb begin
    state_nxt = state;
    latch_sel = 1'b0;
    clr_words = 1'b0;
    case (state)
      IDLE: begin
        if (en_i) begin
          state_nxt = RUN;
          latch_sel = 1'b1;
        end
      end
      RUN: begin
        if (sel_change) begin
          state_nxt = DRAIN;
        end else if (!en_i && empty) begin
          state_nxt = IDLE;
        end
      end
      DRAIN: begin
        if (empty) begin
          latch_sel = 1'b1;
          clr_words = 1'b1;
          state_nxt = en_i ? RUN : IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state   <= IDLE;
      cur_sel <= '0;
    end else if (clear_i) begin
      state   <= IDLE;
      cur_sel <= '0;
    end else begin
      state <= state_nxt;
      if (latch_sel) begin
        cur_sel <= sel_i;
      end
    end
  end

  // Pair storage needs no reset: occupancy is tracked only by the pointers.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      buf_sel[wr_ptr]  <= sel_i;
      buf_addr[wr_ptr] <= addr_i[AW-1:0];
      buf_data[wr_ptr] <= data_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      mem_we_o    <= '0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      words_o     <= '0;
      err_o       <= '0;
    end else if (clear_i) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      mem_we_o    <= '0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      words_o     <= '0;
      err_o       <= '0;
    end else begin
      if (accept) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (accept && !pop) begin
        count <= count + 1'b1;
      end else if (!accept && pop) begin
        count <= count - 1'b1;
      end

      if (!mem_stall_i) begin
        if (pop && head_ok) begin
          mem_we_o    <= head_we;
          mem_addr_o  <= head_addr[AW-1:2];
          mem_wdata_o <= head_data;
        end else begin
          mem_we_o <= '0;
        end
      end

      if (pop && head_misalign) begin
        err_o[0] <= 1'b1;
      end
      if (pop && head_bad_sel) begin
        err_o[1] <= 1'b1;
      end

      // A select change restarts the count; it takes priority over an old-select
      // write completing in the same cycle.
      if (clr_words) begin
        words_o <= '0;
      end else if ((mem_we_o != '0) && !mem_stall_i && (words_o != 16'hFFFF)) begin
        words_o <= words_o + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_panda_mem_loader.sv
// tb_panda_mem_loader
//   Self-checking bench for panda_mem_loader: a table of per-cycle vectors,
//   hand-written select-switch and reset/clear sequences, and randomized bursts
//   checked against a queue-based transaction model.
module tb_panda_mem_loader;

  localparam int unsigned DATA_W    = 32;
  localparam int unsigned ADDR_W    = 12;
  localparam int unsigned BUF_DEPTH = 2;

  localparam int unsigned DA  = 32'hA0A0_0001;
  localparam int unsigned DB  = 32'hB0B0_0002;
  localparam int unsigned DC  = 32'hC0C0_0003;
  localparam int unsigned DD  = 32'hD0D0_0004;
  localparam int unsigned DP  = 32'h5500_0000;
  localparam int unsigned DE  = 32'hEEEE_0000;
  localparam int unsigned DS  = 32'h5E15_0000;
  localparam int unsigned DR  = 32'h7E57_0000;

  logic              clk = 1'b0;
  logic              rst_i = 1'b0;
  logic              clear_i = 1'b0;
  logic              en_i = 1'b0;
  logic [2:0]        sel_i = '0;
  logic              addr_valid_i = 1'b0;
  logic [31:0]       addr_i = '0;
  logic              addr_ready_o;
  logic              data_valid_i = 1'b0;
  logic [DATA_W-1:0] data_i = '0;
  logic              data_ready_o;
  logic [4:0]        mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_wdata_o;
  logic              mem_stall_i = 1'b0;
  logic [15:0]       words_o;
  logic              busy_o;
  logic [1:0]        err_o;

  panda_mem_loader #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .BUF_DEPTH(BUF_DEPTH)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .clear_i     (clear_i),
    .en_i        (en_i),
    .sel_i       (sel_i),
    .addr_valid_i(addr_valid_i),
    .addr_i      (addr_i),
    .addr_ready_o(addr_ready_o),
    .data_valid_i(data_valid_i),
    .data_i      (data_i),
    .data_ready_o(data_ready_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_stall_i (mem_stall_i),
    .words_o     (words_o),
    .busy_o      (busy_o),
    .err_o       (err_o)
  );

  always #5 clk = ~clk;

  int   n_vec = 0;
  int   n_err = 0;
  logic ra, rd;

  typedef struct {
    int unsigned clr, en, sel, va, vd, addr, data, stall;
    int unsigned rdy, we, ma, wd, w, e, b;
  } vec_t;
  vec_t tbl[$];

  typedef struct {
    int unsigned tag, addr, data;
  } pair_t;

  function automatic vec_t mk(input int unsigned clr, en, sel, va, vd, addr, data, stall,
                              input int unsigned rdy, we, ma, wd, w, e, b);
    vec_t v;
    v.clr = clr; v.en = en; v.sel = sel; v.va = va; v.vd = vd;
    v.addr = addr; v.data = data; v.stall = stall;
    v.rdy = rdy; v.we = we; v.ma = ma; v.wd = wd; v.w = w; v.e = e; v.b = b;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_rdy(input string tag, input int unsigned exp);
    chk($sformatf("%s addr_ready", tag), 64'(ra), 64'(exp));
    chk($sformatf("%s data_ready", tag), 64'(rd), 64'(exp));
  endtask

  task automatic chk_outs(input string tag, input int unsigned we, ma, wd, w, e, b);
    chk($sformatf("%s mem_we", tag),    64'(mem_we_o),    64'(we));
    chk($sformatf("%s mem_addr", tag),  64'(mem_addr_o),  64'(ma));
    chk($sformatf("%s mem_wdata", tag), 64'(mem_wdata_o), 64'(wd));
    chk($sformatf("%s words", tag),     64'(words_o),     64'(w));
    chk($sformatf("%s err", tag),       64'(err_o),       64'(e));
    chk($sformatf("%s busy", tag),      64'(busy_o),      64'(b));
  endtask

  task automatic drive(input int unsigned clr, en, sel, va, vd, addr, data, stall);
    clear_i      = 1'(clr);
    en_i         = 1'(en);
    sel_i        = 3'(sel);
    addr_valid_i = 1'(va);
    data_valid_i = 1'(vd);
    addr_i       = addr;
    data_i       = data;
    mem_stall_i  = 1'(stall);
  endtask

  // Called at posedge+1: readies sampled at the negedge, registered outputs
  // become observable at the following posedge+1.
  task automatic step();
    @(negedge clk);
    ra = addr_ready_o;
    rd = data_ready_o;
    @(posedge clk);
    #1;
  endtask

  task automatic do_clear();
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    step();
  endtask

  // Leaves one write held by a stall and two pairs buffered behind it.
  task automatic preload(input string tag);
    drive(0, 1, 0, 1, 1, 'h0, DR + 0, 0); step();
    drive(0, 1, 0, 1, 1, 'h4, DR + 1, 0); step();
    drive(0, 1, 0, 1, 1, 'h8, DR + 2, 1); step();
    chk_rdy($sformatf("%s push1", tag), 1);
    drive(0, 1, 0, 1, 1, 'hC, DR + 3, 1); step();
    chk_rdy($sformatf("%s push2", tag), 1);
    drive(0, 1, 0, 0, 0, 0, 0, 1); step();
    chk_outs($sformatf("%s loaded", tag), 'b00001, 1, DR + 1, 1, 0, 1);
  endtask

  task automatic run_random(input int bursts);
    pair_t       q[$];
    pair_t       p;
    int unsigned m_we, m_addr, m_data, m_words, m_err, m_busy;
    int unsigned sel, en, va, vd, addr, data, stall, exp_rdy, idx;
    int          pre_size;
    logic        bad_tag, mis;
    for (int b = 0; b < bursts; b++) begin
      do_clear();
      q.delete();
      m_we = 0; m_addr = 0; m_data = 0; m_words = 0; m_err = 0;
      sel = $urandom_range(0, 7);
      for (int c = 0; c < 60; c++) begin
        en    = (c < 50) ? 1 : 0;
        va    = (en != 0 && $urandom_range(0, 9) < 7) ? 1 : 0;
        vd    = (en != 0 && $urandom_range(0, 9) < 7) ? 1 : 0;
        stall = (c < 50 && $urandom_range(0, 3) == 0) ? 1 : 0;
        addr  = ($urandom & 32'hFFFF_FFFC) |
                (($urandom_range(0, 7) == 0) ? $urandom_range(1, 3) : 0);
        data  = $urandom;
        exp_rdy  = (en != 0 && va != 0 && vd != 0 && q.size() < int'(BUF_DEPTH)) ? 1 : 0;
        pre_size = q.size();
        drive(0, en, sel, va, vd, addr, data, stall);
        step();
        chk_rdy($sformatf("rnd b%0d c%0d", b, c), exp_rdy);
        if (exp_rdy != 0) begin
          p.tag = sel; p.addr = addr; p.data = data;
          q.push_back(p);
        end
        if (stall == 0) begin
          if (m_we != 0 && m_words < 'hFFFF) m_words++;
          m_we = 0;
          if (q.size() > 0) begin
            p = q.pop_front();
            bad_tag = (p.tag == 2 || p.tag == 3 || p.tag == 7);
            mis     = (p.addr % 4) != 0;
            if (mis)     m_err = m_err | 1;
            if (bad_tag) m_err = m_err | 2;
            if (!bad_tag && !mis) begin
              idx    = (p.tag < 2) ? p.tag : p.tag - 2;
              m_we   = 1 << idx;
              m_addr = (p.addr >> 2) % (1 << ADDR_W);
              m_data = p.data;
            end
          end
        end
        m_busy = (en != 0 || pre_size != 0) ? 1 : 0;
        chk_outs($sformatf("rnd b%0d c%0d", b, c), m_we, m_addr, m_data, m_words, m_err, m_busy);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t v;

    // clr en sel va vd addr data stall | rdy we ma wd words err busy
    tbl.push_back(mk(1,0,0,0,0,'h000,0,     0, 0,'b00000,'h00,0,     0,0,0));
    // aligned streaming, config memory
    tbl.push_back(mk(0,1,0,1,1,'h000,DA,    0, 1,'b00001,'h00,DA,    0,0,1));
    tbl.push_back(mk(0,1,0,1,1,'h004,DB,    0, 1,'b00001,'h01,DB,    1,0,1));
    tbl.push_back(mk(0,1,0,1,1,'h008,DC,    0, 1,'b00001,'h02,DC,    2,0,1));
    tbl.push_back(mk(0,1,0,0,0,'h000,0,     0, 0,'b00000,'h02,DC,    3,0,1));
    tbl.push_back(mk(0,0,0,0,0,'h000,0,     0, 0,'b00000,'h02,DC,    3,0,0));
    tbl.push_back(mk(1,0,0,0,0,'h000,0,     0, 0,'b00000,'h00,0,     0,0,0));
    // stream skew, instruction memory
    tbl.push_back(mk(0,1,1,1,0,'h010,DD,    0, 0,'b00000,'h00,0,     0,0,1));
    tbl.push_back(mk(0,1,1,1,0,'h010,DD,    0, 0,'b00000,'h00,0,     0,0,1));
    tbl.push_back(mk(0,1,1,1,0,'h010,DD,    0, 0,'b00000,'h00,0,     0,0,1));
    tbl.push_back(mk(0,1,1,1,1,'h010,DD,    0, 1,'b00010,'h04,DD,    0,0,1));
    tbl.push_back(mk(0,1,1,0,0,'h000,0,     0, 0,'b00000,'h04,DD,    1,0,1));
    tbl.push_back(mk(0,0,1,0,0,'h000,0,     0, 0,'b00000,'h04,DD,    1,0,0));
    tbl.push_back(mk(1,0,0,0,0,'h000,0,     0, 0,'b00000,'h00,0,     0,0,0));
    // backpressure, weight-conv memory
    tbl.push_back(mk(0,1,5,1,1,'h100,DP+0,  0, 1,'b01000,'h40,DP+0,  0,0,1));
    tbl.push_back(mk(0,1,5,1,1,'h104,DP+1,  1, 1,'b01000,'h40,DP+0,  0,0,1));
    tbl.push_back(mk(0,1,5,1,1,'h108,DP+2,  1, 1,'b01000,'h40,DP+0,  0,0,1));
    tbl.push_back(mk(0,1,5,1,1,'h10C,DP+3,  1, 0,'b01000,'h40,DP+0,  0,0,1));
    tbl.push_back(mk(0,1,5,1,1,'h10C,DP+3,  0, 0,'b01000,'h41,DP+1,  1,0,1));
    tbl.push_back(mk(0,1,5,1,1,'h10C,DP+3,  0, 1,'b01000,'h42,DP+2,  2,0,1));
    tbl.push_back(mk(0,1,5,0,0,'h000,0,     0, 0,'b01000,'h43,DP+3,  3,0,1));
    tbl.push_back(mk(0,1,5,0,0,'h000,0,     0, 0,'b00000,'h43,DP+3,  4,0,1));
    tbl.push_back(mk(0,0,5,0,0,'h000,0,     0, 0,'b00000,'h43,DP+3,  4,0,0));
    tbl.push_back(mk(1,0,0,0,0,'h000,0,     0, 0,'b00000,'h00,0,     0,0,0));
    // errors: misaligned to weight-fc, then a pair on the null select
    tbl.push_back(mk(0,1,6,1,1,'h006,DE+1,  0, 1,'b00000,'h00,0,     0,1,1));
    tbl.push_back(mk(0,1,7,1,1,'h020,DE+2,  0, 0,'b00000,'h00,0,     0,1,1));
    tbl.push_back(mk(0,1,7,1,1,'h020,DE+2,  0, 0,'b00000,'h00,0,     0,1,1));
    tbl.push_back(mk(0,1,7,1,1,'h020,DE+2,  0, 1,'b00000,'h00,0,     0,3,1));
    tbl.push_back(mk(0,1,7,0,0,'h000,0,     0, 0,'b00000,'h00,0,     0,3,1));
    tbl.push_back(mk(0,0,7,0,0,'h000,0,     0, 0,'b00000,'h00,0,     0,3,0));

    // reset state
    #1 rst_i = 1'b1;
    #2;
    ra = addr_ready_o;
    rd = data_ready_o;
    chk_rdy("reset", 0);
    chk_outs("reset", 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1 rst_i = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      v = tbl[i];
      drive(v.clr, v.en, v.sel, v.va, v.vd, v.addr, v.data, v.stall);
      step();
      chk_rdy($sformatf("row%0d", i), v.rdy);
      chk_outs($sformatf("row%0d", i), v.we, v.ma, v.wd, v.w, v.e, v.b);
    end

    // select switch: one instruction pair still buffered when sel moves to 4
    do_clear();
    drive(0, 1, 1, 1, 1, 'h40, DS + 0, 1); step();
    chk_rdy("sw0", 1);
    chk_outs("sw0", 0, 0, 0, 0, 0, 1);
    drive(0, 1, 1, 1, 1, 'h44, DS + 1, 0); step();
    chk_rdy("sw1", 1);
    chk_outs("sw1", 'b00010, 'h10, DS + 0, 0, 0, 1);
    drive(0, 1, 4, 1, 1, 'h80, DS + 2, 0); step();
    chk_rdy("sw2 drain entry", 0);
    chk_outs("sw2", 'b00010, 'h11, DS + 1, 1, 0, 1);
    step();
    chk_rdy("sw3 drain", 0);
    chk_outs("sw3", 0, 'h11, DS + 1, 0, 0, 1);
    step();
    chk_rdy("sw4", 1);
    chk_outs("sw4", 'b00100, 'h20, DS + 2, 0, 0, 1);
    drive(0, 1, 4, 0, 0, 0, 0, 0); step();
    chk_outs("sw5", 0, 'h20, DS + 2, 1, 0, 1);
    drive(0, 0, 4, 0, 0, 0, 0, 0); step();
    chk_outs("sw6", 0, 'h20, DS + 2, 1, 0, 0);

    // asynchronous reset with pairs buffered
    do_clear();
    preload("arst");
    #2 rst_i = 1'b1;
    #1;
    ra = addr_ready_o;
    rd = data_ready_o;
    chk_rdy("arst now", 0);
    chk_outs("arst now", 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1 rst_i = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0); step();
    chk_outs("arst after1", 0, 0, 0, 0, 0, 0);
    step();
    chk_outs("arst after2", 0, 0, 0, 0, 0, 0);

    // synchronous clear with pairs buffered
    do_clear();
    preload("sclr");
    drive(1, 1, 0, 0, 0, 0, 0, 0);
    #3;
    chk("sclr before edge mem_we", 64'(mem_we_o), 64'('b00001));
    step();
    chk_rdy("sclr", 0);
    chk_outs("sclr", 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0); step();
    chk_outs("sclr after1", 0, 0, 0, 0, 0, 0);
    step();
    chk_outs("sclr after2", 0, 0, 0, 0, 0, 0);

    run_random(12);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/panda_mem_loader.md
Name: panda_mem_loader

Overview:
- Write-back stage between the address/data input streams and the PANDA accelerator memories (config, instruction, activation, weight-conv, weight-fc).
- Pairs one address token with one data token while the load controller enables streaming, buffers the pair, and issues one write to the memory given by the select code.
- Returns word counts and error flags to the controller.

Parameters:
- DATA_W, 32: data word width.
- ADDR_W, 12: word-address width for each memory.
- BUF_DEPTH, 2: pair-buffer depth. Must be a power of 2 and at least 2.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous active-high reset.
- clear_i  in  1  synchronous soft clear.
- en_i  in  1  stream enable from the load controller.
- sel_i  in  3  memory select: 0 config, 1 instruction, 4 activation, 5 weight-conv, 6 weight-fc, 7 null. Codes 2 and 3 are illegal.
- addr_valid_i  in  1  address token valid.
- addr_i  in  32  byte address.
- addr_ready_o  out  1  address token accepted.
- data_valid_i  in  1  data token valid.
- data_i  in  DATA_W  data word.
- data_ready_o  out  1  data token accepted.
- mem_we_o  out  5  one-hot write enable. Bit order: config, instruction, activation, weight-conv, weight-fc.
- mem_addr_o  out  ADDR_W  word address, equal to addr[ADDR_W+1:2].
- mem_wdata_o  out  DATA_W  write data.
- mem_stall_i  in  1  target memory busy; hold the current write.
- words_o  out  16  words written since the last clear or select change.
- busy_o  out  1  high when the FSM is not IDLE or the buffer is non-empty.
- err_o  out  2  sticky flags: [0] misaligned address, [1] illegal or null select with data.

Behaviour:
- Reset or clear_i gives: FSM in IDLE, buffer empty, all outputs 0, words_o=0, err_o=0. Reset is asynchronous, clear_i is synchronous, and both take effect mid-operation. Buffered pairs are discarded and no write is issued in the clearing cycle.
- Accept rule: accept = en_i & addr_valid_i & data_valid_i & ~full & (state!=DRAIN).
  - addr_ready_o = data_ready_o = accept, purely combinational.
  - A token is never taken alone. If only one stream is valid, neither ready is asserted.
- Each accepted pair is pushed with the sel_i value tagged on it.
- Write stage: the buffer head issues a write when non-empty and ~mem_stall_i.
  - The write pops the head in the same cycle.
  - mem_we_o is registered. The earliest write appears one cycle after the accept (latency 1).
  - mem_addr_o and mem_wdata_o are valid only while mem_we_o is non-zero; otherwise they hold their last value.
  - When mem_stall_i is high, the registered write holds stable and nothing pops.
- Dropped pairs (no write; the pop still happens and words_o does not increment):
  - addr_i[1:0]!=0: set err_o[0].
  - tag is 2, 3 or 7: set err_o[1].
- words_o increments by 1 on each completed write, meaning mem_we_o!=0 & ~mem_stall_i. It saturates at 0xFFFF.
- Push and pop in the same cycle leave the occupancy unchanged. Full blocks accept only; a pop in that cycle frees the slot for the next cycle, not the current one.
- FSM:
  - IDLE: if en_i, go to RUN and latch sel_i as cur_sel.
  - RUN: if sel_i!=cur_sel while en_i, go to DRAIN; no accepts from that cycle on.
  - RUN: if ~en_i and the buffer is empty, go to IDLE.
  - DRAIN: when the buffer is empty, latch the new sel_i, clear words_o, and return to RUN (or to IDLE if ~en_i).
  - This guarantees writes never mix two selects out of order.
- busy_o falls the cycle after the final write completes with en_i low.

Test Plan:
- Aligned streaming: en_i=1, sel=0, addresses 0x0,0x4,0x8 with data A,B,C, both streams valid every cycle, no stall. Required: mem_we_o=00001 for three consecutive cycles starting one cycle after the first accept, mem_addr_o=0,1,2, words_o=3, err_o=0.
- Stream skew: data_valid_i arrives 3 cycles after addr_valid_i. Required: no ready asserted during the 3 cycles; both readies pulse together once data is valid; a single write follows.
- Backpressure: sel=5, 4 pairs, mem_stall_i high for 3 cycles mid-stream. Required: the buffer fills to 2, readies drop, mem_we_o=01000 holds its address and data stable through the stall, all 4 words are written in order, words_o=4.
- Select switch: 2 pairs with sel=1, then sel_i changes to 4 while one pair is still buffered. Required: DRAIN entered; the pending write goes out with mem_we_o=00010; words_o resets to 0; the next pair is written with mem_we_o=00100.
- Errors: address 0x6 with sel=6, then a pair with sel=7. Required: no writes, err_o=11 sticky, words_o=0, and both pairs are consumed.
- Reset and clear mid-stream: rst_i asserted asynchronously with 2 pairs buffered. Required: outputs go to 0 immediately without waiting for a clock edge. Repeating the scenario with clear_i gives the same outputs from the next edge, with no write issued.
